// File: rtl/smvm_row_collector.sv
// -----------------------------------------------------------------------------
// smvm_row_collector
//
// Sits downstream of the SMVM core. The core emits each 28-bit row result as two
// serial 14-bit words (high half first, then low half). This block pairs the
// halves back up, tags each result with its row index, buffers it in a small
// FIFO and presents it over a valid/ready handshake. It also flags words that
// arrive when no matrix is being collected and rows lost to a full FIFO.
//
// Parameters
//   DEPTH   FIFO entries (power of 2, >= 2)
//   ROW_W   width of the row count / row index
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, begins a new matrix (honoured in IDLE only)
//   rows_cfg   in   number of rows expected, sampled on start
//   abort      in   synchronous flush back to IDLE, FIFO emptied
//   in_valid   in   core output valid (no backpressure)
//   in_data    in   core output word (one 14-bit half)
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head when out_valid & out_ready
//   out_data   out  {hi, lo} row result, two's complement
//   out_row    out  row index of out_data
//   out_last   out  head is the final row of the matrix
//   busy       out  not in IDLE
//   done       out  1-cycle pulse when all rows are collected and drained
//   ovf_err    out  sticky: a row arrived while the FIFO was full
//   stray_err  out  sticky: in_valid seen outside COLLECT
// -----------------------------------------------------------------------------
module smvm_row_collector #(
    parameter int DEPTH = 8,
    parameter int ROW_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ROW_W-1:0]        rows_cfg,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [13:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [27:0]      out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf_err,
    output logic                    stray_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // control state (reset)
    logic               half;
    logic [ROW_W-1:0]   row_cnt;
    logic [ROW_W-1:0]   rows_q;
    logic               vld_p0;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               zero_done;

    // datapath state (no reset; qualified by control)
    logic [13:0]        hi_p0;
    logic signed [27:0] data_p0;
    logic [ROW_W-1:0]   row_p0;
    logic               last_p0;
    logic signed [27:0] mem_data [DEPTH];
    logic [ROW_W-1:0]   mem_row  [DEPTH];
    logic               mem_last [DEPTH];

    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               take;
    logic               lo_take;
    logic [ROW_W-1:0]   last_idx;
    logic               is_last_row;
    logic               wr_en;
    logic               drop;
    logic               drain_exit;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(DEPTH));
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;

    // Words are consumed only while collecting; abort overrides everything.
    assign take        = (state == S_COLLECT) && in_valid && !abort;
    assign lo_take     = take && half;
    assign last_idx    = rows_q - 1'b1;
    assign is_last_row = (row_cnt == last_idx);

    // A pending row enters the FIFO when there is room, or when the head
    // leaves in the same cycle (full FIFO, simultaneous push and pop).
    assign wr_en       = vld_p0 && (!fifo_full || pop);
    assign drop        = vld_p0 && fifo_full && !pop;

    // The last row may still sit in the assembly register, so DRAIN must
    // also wait for that register to empty.
    assign drain_exit  = (state == S_DRAIN) && fifo_empty && !vld_p0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && (rows_cfg != '0)) state_nxt = S_COLLECT;
            S_COLLECT: if (lo_take && is_last_row)    state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_exit)                state_nxt = S_IDLE;
            default:                                  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            half      <= 1'b0;
            row_cnt   <= '0;
            rows_q    <= '0;
            vld_p0    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_err   <= 1'b0;
            stray_err <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            zero_done <= (state == S_IDLE) && start && (rows_cfg == '0) && !abort;
            if (abort) begin
                half   <= 1'b0;
                vld_p0 <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (in_valid && (state != S_COLLECT)) stray_err <= 1'b1;
                if (drop)                             ovf_err   <= 1'b1;

                // start wins over a same-cycle stray word
                if (start && (state == S_IDLE)) begin
                    ovf_err   <= 1'b0;
                    stray_err <= 1'b0;
                    row_cnt   <= '0;
                    half      <= 1'b0;
                    rows_q    <= rows_cfg;
                end

                if (take) begin
                    if (!half) begin
                        half <= 1'b1;
                    end else begin
                        half    <= 1'b0;
                        row_cnt <= row_cnt + 1'b1;
                    end
                end

                vld_p0 <= lo_take;

                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                case ({wr_en, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // p0: high half held, then the full row assembled with its tag
    always_ff @(posedge clk) begin
        if (take && !half) hi_p0 <= in_data;
        if (lo_take) begin
            data_p0 <= {hi_p0, in_data};
            row_p0  <= row_cnt;
            last_p0 <= is_last_row;
        end
        // p1: FIFO storage
        if (wr_en) begin
            mem_data[wr_ptr] <= data_p0;
            mem_row[wr_ptr]  <= row_p0;
            mem_last[wr_ptr] <= last_p0;
        end
    end

    // Head outputs are forced to zero while empty so they are defined from reset.
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_row  = out_valid ? mem_row[rd_ptr]  : '0;
    assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

    assign busy = (state != S_IDLE);
    assign done = zero_done || (drain_exit && !abort);

endmodule
